// File: rtl/pipelined_control_unit.sv
// ID-stage decoder whose control bundle is registered into EX, with a
// HI/LO interlock, a handshaked GPIO read and stall/flush handling.
module pipelined_control_unit #(
    parameter int unsigned MULT_CYCLES  = 4,
    parameter int unsigned LUI_SHAMT    = 16,
    parameter int unsigned GPIO_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_ID,
    input  logic [31:0] instruction_ID,
    input  logic        stall_in,
    input  logic        flush,
    input  logic        gpio_in_ack,
    output logic        valid_EX,
    output logic [3:0]  alu_op_EX,
    output logic [4:0]  shamt_EX,
    output logic        enhilo_EX,
    output logic [1:0]  regsel_EX,
    output logic        regwrite_EX,
    output logic        rdrt_EX,
    output logic        memwrite_EX,
    output logic [1:0]  alu_src_EX,
    output logic        gpio_out_EX,
    output logic        gpio_in_EX,
    output logic        gpio_err_EX,
    output logic        illegal_EX,
    output logic        stall_FETCH,
    output logic        mult_busy
);
    localparam int TW = (GPIO_TIMEOUT > 1) ? $clog2(GPIO_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO = TW'(GPIO_TIMEOUT);

    typedef struct packed {
        logic       valid;
        logic [3:0] alu_op;
        logic [4:0] shamt;
        logic       enhilo;
        logic [1:0] regsel;
        logic       regwrite;
        logic       rdrt;
        logic       memwrite;
        logic [1:0] alu_src;
        logic       gpio_out;
        logic       gpio_in;
        logic       gpio_err;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {G_IDLE, G_WAIT} gpio_state_t;

    ctrl_t       dec, ex, ex_next;
    gpio_state_t gst, gst_next;
    logic [TW-1:0] timer, timer_next;
    logic [3:0]  cnt, cnt_next;
    logic        bad, hilo_use, interlock, load_ex;
    logic        gpio_pending, timeout_fire, hold;
    logic [5:0]  op, fn;
    logic [4:0]  sh;

    assign op = instruction_ID[31:26];
    assign fn = instruction_ID[5:0];
    assign sh = instruction_ID[10:6];

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        bad       = 1'b0;
        if (instruction_ID != 32'd0) begin
            if (op == 6'd0) begin
                dec.regwrite = 1'b1;
                case (fn)
                    6'b100000, 6'b100001: dec.alu_op = 4'b0100;
                    6'b100010, 6'b100011: dec.alu_op = 4'b0101;
                    6'b100100: dec.alu_op = 4'b0000;
                    6'b100101: dec.alu_op = 4'b0001;
                    6'b100111: dec.alu_op = 4'b0010;
                    6'b100110: dec.alu_op = 4'b0011;
                    6'b101010: dec.alu_op = 4'b1100;
                    6'b101011: dec.alu_op = 4'b1101;
                    6'b000000: begin
                        dec.alu_op = 4'b1000;
                        dec.shamt  = sh;
                    end
                    6'b000010: begin
                        dec.alu_op   = 4'b1001;
                        dec.shamt    = sh;
                        dec.gpio_out = (sh == 5'd0);
                    end
                    6'b000011: begin
                        dec.alu_op  = 4'b1010;
                        dec.shamt   = sh;
                        dec.gpio_in = (sh == 5'd0);
                        dec.regsel  = (sh == 5'd0) ? 2'd1 : 2'd0;
                    end
                    6'b011000, 6'b011001: begin
                        dec.alu_op   = {3'b011, fn[0]};
                        dec.enhilo   = 1'b1;
                        dec.regwrite = 1'b0;
                    end
                    6'b010000: dec.regsel = 2'd1;
                    6'b010010: dec.regsel = 2'd2;
                    default:   bad = 1'b1;
                endcase
            end else begin
                dec.regwrite = 1'b1;
                dec.rdrt     = 1'b1;
                case (op)
                    6'b001000, 6'b001001: begin
                        dec.alu_op  = 4'b0100;
                        dec.alu_src = 2'd1;
                    end
                    6'b001010: begin
                        dec.alu_op  = 4'b1100;
                        dec.alu_src = 2'd1;
                    end
                    6'b001100: dec.alu_src = 2'd2;
                    6'b001101: begin
                        dec.alu_op  = 4'b0001;
                        dec.alu_src = 2'd2;
                    end
                    6'b001110: begin
                        dec.alu_op  = 4'b0011;
                        dec.alu_src = 2'd2;
                    end
                    6'b001111: begin
                        dec.alu_op  = 4'b1000;
                        dec.shamt   = 5'(LUI_SHAMT);
                        dec.alu_src = 2'd2;
                    end
                    default: bad = 1'b1;
                endcase
            end
        end
        if (bad) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
    end

    // HI/LO is free for a reader issued while the counter is on its last cycle
    assign hilo_use  = (op == 6'd0) && (fn == 6'b010000 || fn == 6'b010010 ||
                                        fn == 6'b011000 || fn == 6'b011001);
    assign interlock = instr_valid_ID && hilo_use && (cnt > 4'd1);

    assign gpio_pending = ex.gpio_in && !gpio_in_ack;
    assign timeout_fire = (GPIO_TIMEOUT != 0) && (gst == G_WAIT) &&
                          gpio_pending && (timer == TO);
    assign hold         = stall_in || gpio_pending;
    assign load_ex      = !hold && !flush && !interlock && instr_valid_ID;
    assign stall_FETCH  = hold || (!flush && interlock);

    // On timeout the read stays in EX one more cycle, marked failed
    always_comb begin
        ex_next = ex;
        if (timeout_fire) begin
            ex_next.regwrite = 1'b0;
            ex_next.gpio_in  = 1'b0;
            ex_next.gpio_err = 1'b1;
        end else if (hold) begin
            ex_next.gpio_err = 1'b0;
        end else if (load_ex) begin
            ex_next = dec;
        end else begin
            ex_next = '0;
        end
    end

    always_comb begin
        gst_next   = gst;
        timer_next = timer;
        case (gst)
            G_IDLE: if (gpio_pending) begin
                gst_next   = G_WAIT;
                timer_next = TW'(1);
            end
            G_WAIT: if (!gpio_pending || timeout_fire) begin
                gst_next   = G_IDLE;
                timer_next = '0;
            end else if (timer != TO) begin
                timer_next = timer + TW'(1);
            end
            default: gst_next = G_IDLE;
        endcase
    end

    always_comb begin
        cnt_next = cnt;
        if (load_ex && dec.enhilo)
            cnt_next = 4'(MULT_CYCLES);
        else if (cnt != 4'd0)
            cnt_next = cnt - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex    <= '0;
            gst   <= G_IDLE;
            timer <= '0;
            cnt   <= '0;
        end else begin
            ex    <= ex_next;
            gst   <= gst_next;
            timer <= timer_next;
            cnt   <= cnt_next;
        end
    end

    assign valid_EX    = ex.valid;
    assign alu_op_EX   = ex.alu_op;
    assign shamt_EX    = ex.shamt;
    assign enhilo_EX   = ex.enhilo;
    assign regsel_EX   = ex.regsel;
    assign regwrite_EX = ex.regwrite;
    assign rdrt_EX     = ex.rdrt;
    assign memwrite_EX = ex.memwrite;
    assign alu_src_EX  = ex.alu_src;
    assign gpio_out_EX = ex.gpio_out;
    assign gpio_in_EX  = ex.gpio_in;
    assign gpio_err_EX = ex.gpio_err;
    assign illegal_EX  = ex.illegal;
    assign mult_busy   = (cnt != 4'd0);
endmodule
